iir_biquad_tdm: RTL and testbench
=================================

Name: iir_biquad_tdm

Overview:
- Parametrised second-order IIR section (biquad). Successor to the fixed-coefficient, single-channel, shift-add second tap.
- Adds runtime-programmable coefficients and NCH time-multiplexed channels, each with its own history.
- Uses one shared sequential multiply-accumulate, with valid/ready handshakes on input and output.
- Optional rounding and saturation. Instances cascade to build higher-order IIR chains in the filter datapath.

Parameters:
- DW_IN, 8, signed input sample width
- DW_OUT, 9, signed output sample width (also the width of the y history)
- CW, 14, signed coefficient width
- FRAC, 11, coefficient fractional bits (scale 2^FRAC)
- NCH, 1, number of channels (1..16); CHW = max(1, clog2(NCH))
- ROUND, 0, 0 = floor (arithmetic shift), 1 = round-half-up
- SAT, 1, 0 = wrap to DW_OUT, 1 = clamp to the DW_OUT range

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DW_IN  signed sample x[n]
- in_ch  in  CHW  channel tag of the sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  DW_OUT  signed y[n]
- out_ch  out  CHW  channel tag of the result
- coef_we  in  1  coefficient write strobe
- coef_sel  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 invalid
- coef_wdata  in  CW  signed coefficient
- hist_clr  in  1  synchronous clear of all channel histories
- err  out  2  one-cycle pulses: [0] = coefficient write rejected, [1] = bad channel

Behaviour:
- Difference equation:
  - acc = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2
  - y = acc >>> FRAC, plus 2^(FRAC−1) before the shift when ROUND=1
  - ACC_W = max(DW_IN, DW_OUT) + CW + 3; no internal overflow is possible.
- Output conversion: SAT=1 clamps y to [−2^(DW_OUT−1), 2^(DW_OUT−1)−1]; SAT=0 keeps the low DW_OUT bits.
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_ch=0, err=0
  - all histories = 0
  - coefficients = b0 2048, b1 988, b2 2048, a1 −1099, a2 699
  - State = IDLE.
- FSM states: IDLE → MAC0..MAC4 (b0·x, b1·x1, b2·x2, a1·y1, a2·y2; one product per cycle) → OUT → IDLE.
- Timing:
  - Accept on in_valid & in_ready in cycle T.
  - MAC occupies T+1..T+5; out_valid rises at T+6, so latency is 6 cycles.
  - in_ready=1 only in IDLE, so throughput is at most 1 sample per 7 cycles.
- OUT state:
  - out_data and out_ch are held stable until out_valid & out_ready.
  - The channel history (x2←x1, x1←x, y2←y1, y1←y_out, post-saturation) is committed in the handshake cycle.
  - Next cycle: IDLE, in_ready=1.
- Bad channel (in_ch ≥ NCH): the sample is accepted and dropped, err[1] pulses, state stays IDLE.
- Coefficient writes:
  - Applied only in IDLE, written at the clock edge.
  - A write and an accepted sample in the same cycle: the sample uses the old value.
  - A write outside IDLE, or with coef_sel ≥ 5, is ignored and err[0] pulses.
- hist_clr:
  - In IDLE, zeroes all histories in the same edge.
  - Outside IDLE it is ignored; the current sample completes normally.
- Asynchronous reset mid-operation aborts any sample:
  - all state returns to reset values, including the default coefficients
  - no partial output is emitted
  - in_ready is high on the first edge after release.

Decomposition:
- Package iir_pkg holds:
  - coefficient select constants C_B0..C_A2
  - FSM state enum
  - default coefficient localparams
  - ACC_W / CHW helper functions
- Sub-module iir_mac (single signed CW×max(DW_IN,DW_OUT) multiplier feeding an ACC_W accumulator with clear/accumulate/subtract controls). Controller, histories and coefficients stay in the top module.

Test Plan:
- Impulse, defaults, NCH=1, ROUND=0: x = 1, 0, 0 → y = 1, 1 (acc 2087), then subsequent values match the golden model bit-exactly; each out_valid arrives 6 cycles after acceptance.
- DC step 127, SAT=1: output clamps at 255 (DC gain ≈ 3.08) and never wraps. Rerun with SAT=0: wrapped values match the model.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → out_data and out_ch stable, in_ready=0. The handshake then commits history, and in_ready=1 on the next cycle.
- NCH=2 interleaved: ch0 impulse 1, ch1 all zeros → ch1 outputs all 0 and ch0 matches the single-channel sequence. in_ch=2 → err[1] pulse, no output.
- Write b0=1024 in IDLE, then x=4 → y=2. A write during MAC3 → err[0] pulse, coefficient unchanged. Also check a same-cycle write plus sample (sample uses old value) and coef_sel=6 (rejected).
- Assert rst during MAC2 → no out_valid. Afterwards histories are 0 and coefficients are defaults; impulse test 1 reproduces exactly.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the time-multiplexed biquad.
//   - coefficient select codes written through coef_sel
//   - controller state encoding
//   - power-up coefficient set (Q.FRAC with FRAC = 11)
//   - width helpers for the accumulator and the channel tag
package iir_pkg;

  localparam logic [2:0] C_B0 = 3'd0;
  localparam logic [2:0] C_B1 = 3'd1;
  localparam logic [2:0] C_B2 = 3'd2;
  localparam logic [2:0] C_A1 = 3'd3;
  localparam logic [2:0] C_A2 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC0 = 3'd1,
    S_MAC1 = 3'd2,
    S_MAC2 = 3'd3,
    S_MAC3 = 3'd4,
    S_MAC4 = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  localparam int DEF_B0 = 2048;
  localparam int DEF_B1 = 988;
  localparam int DEF_B2 = 2048;
  localparam int DEF_A1 = -1099;
  localparam int DEF_A2 = 699;

  // Five products of a CW x max(DW_IN,DW_OUT) multiply need 3 guard bits.
  function automatic int acc_width(input int dw_in, input int dw_out, input int cw);
    return ((dw_in > dw_out) ? dw_in : dw_out) + cw + 3;
  endfunction

  function automatic int ch_width(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/iir_mac.sv
// Shared multiply-accumulate for the biquad controller.
// One signed coef x opnd product per enabled cycle is added to or
// subtracted from the accumulator; clr restarts the sum from zero so the
// first product of a sample loads rather than accumulates.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           update the accumulator this cycle
//   clr          discard the previous sum (used with en on the first term)
//   sub          subtract the product instead of adding it
//   coef, opnd   signed multiplier inputs
//   acc          signed accumulator
module iir_mac
  import iir_pkg::*;
#(
  parameter int AW    = 9,
  parameter int BW    = 14,
  parameter int ACC_W = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    sub,
  input  logic signed [BW-1:0]    coef,
  input  logic signed [AW-1:0]    opnd,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [AW+BW-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  base;

  assign prod     = coef * opnd;
  assign prod_ext = ACC_W'(prod);
  assign base     = clr ? '0 : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= sub ? (base - prod_ext) : (base + prod_ext);
    end
  end

endmodule

// File: rtl/iir_biquad_tdm.sv
// Second-order IIR section with programmable coefficients and NCH
// time-multiplexed channels, each with its own x/y history.
//   acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2,  y = acc >>> FRAC
// One product per cycle through iir_mac: accept -> MAC0..MAC4 -> OUT.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        sample handshake (ready only while idle)
//   in_data, in_ch           signed sample and its channel tag
//   out_valid/out_ready      result handshake, result held until taken
//   out_data, out_ch         signed result and its channel tag
//   coef_we/sel/wdata        coefficient write (b0,b1,b2,a1,a2 = 0..4)
//   hist_clr                 zero all channel histories (idle only)
//   err                      [0] rejected coefficient write, [1] bad channel
module iir_biquad_tdm
  import iir_pkg::*;
#(
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 9,
  parameter int CW     = 14,
  parameter int FRAC   = 11,
  parameter int NCH    = 1,
  parameter int ROUND  = 0,
  parameter int SAT    = 1,
  localparam int CHW   = ch_width(NCH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DW_IN-1:0]  in_data,
  input  logic [CHW-1:0]           in_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DW_OUT-1:0] out_data,
  output logic [CHW-1:0]           out_ch,
  input  logic                     coef_we,
  input  logic [2:0]               coef_sel,
  input  logic signed [CW-1:0]     coef_wdata,
  input  logic                     hist_clr,
  output logic [1:0]               err
);

  localparam int ACC_W = acc_width(DW_IN, DW_OUT, CW);
  localparam int MW    = (DW_IN > DW_OUT) ? DW_IN : DW_OUT;

  localparam logic signed [ACC_W-1:0] HALF =
    (ROUND != 0 && FRAC > 0) ? (ACC_W'(1) <<< ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  localparam logic signed [ACC_W-1:0] YMAX = ACC_W'((64'sd1 <<< (DW_OUT - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] YMIN = ~YMAX;

  state_t state, state_nxt;

  logic signed [CW-1:0]     coef     [5];
  logic signed [CW-1:0]     coef_act [5];
  logic signed [DW_IN-1:0]  x1 [NCH];
  logic signed [DW_IN-1:0]  x2 [NCH];
  logic signed [DW_OUT-1:0] y1 [NCH];
  logic signed [DW_OUT-1:0] y2 [NCH];
  logic signed [DW_IN-1:0]  x_cur;
  logic [CHW-1:0]           ch_cur;

  logic                     idle, accept, ch_ok, start, coef_ok, coef_rej;
  logic                     mac_en, mac_clr, mac_sub;
  logic signed [CW-1:0]     mac_coef;
  logic signed [MW-1:0]     mac_opnd;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DW_OUT-1:0] y_out;

  function automatic logic signed [CW-1:0] def_coef(input int i);
    case (i)
      0:       return CW'(DEF_B0);
      1:       return CW'(DEF_B1);
      2:       return CW'(DEF_B2);
      3:       return CW'(DEF_A1);
      default: return CW'(DEF_A2);
    endcase
  endfunction

  // Floor or round-half-up rescale from Q.FRAC back to integer samples.
  function automatic logic signed [ACC_W-1:0] rescale(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a + HALF;
    return r >>> FRAC;
  endfunction

  function automatic logic signed [DW_OUT-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (SAT != 0 && v > YMAX) return YMAX[DW_OUT-1:0];
    if (SAT != 0 && v < YMIN) return YMIN[DW_OUT-1:0];
    return v[DW_OUT-1:0];
  endfunction

  assign idle     = (state == S_IDLE);
  assign accept   = in_valid && idle;
  assign ch_ok    = ({{(32-CHW){1'b0}}, in_ch} < 32'(NCH));
  assign start    = accept && ch_ok;
  assign coef_ok  = coef_we && idle && (coef_sel <= C_A2);
  assign coef_rej = coef_we && !coef_ok;

  // The accumulator is idle in OUT, so the result is stable until taken.
  assign y_out    = saturate(rescale(acc));
  assign out_data = y_out;
  assign out_ch   = ch_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_MAC0;
      S_MAC0:  state_nxt = S_MAC1;
      S_MAC1:  state_nxt = S_MAC2;
      S_MAC2:  state_nxt = S_MAC3;
      S_MAC3:  state_nxt = S_MAC4;
      S_MAC4:  state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_OUT);
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    mac_sub   = 1'b0;
    mac_coef  = coef_act[C_B0];
    mac_opnd  = MW'(x_cur);
    case (state)
      S_MAC0: begin
        mac_en  = 1'b1;
        mac_clr = 1'b1;
      end
      S_MAC1: begin
        mac_en   = 1'b1;
        mac_coef = coef_act[C_B1];
        mac_opnd = MW'(x1[ch_cur]);
      end
      S_MAC2: begin
        mac_en   = 1'b1;
        mac_coef = coef_act[C_B2];
        mac_opnd = MW'(x2[ch_cur]);
      end
      S_MAC3: begin
        mac_en   = 1'b1;
        mac_sub  = 1'b1;
        mac_coef = coef_act[C_A1];
        mac_opnd = MW'(y1[ch_cur]);
      end
      S_MAC4: begin
        mac_en   = 1'b1;
        mac_sub  = 1'b1;
        mac_coef = coef_act[C_A2];
        mac_opnd = MW'(y2[ch_cur]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= '0;
    else     err <= {accept && !ch_ok, coef_rej};
  end

  // Programmed coefficients; a write lands at the edge ending the idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) coef[i] <= def_coef(i);
    end else if (coef_ok) begin
      coef[coef_sel] <= coef_wdata;
    end
  end

  // Snapshot at acceptance so a write in the same cycle affects only later samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cur  <= '0;
      ch_cur <= '0;
      for (int i = 0; i < 5; i++) coef_act[i] <= def_coef(i);
    end else if (start) begin
      x_cur    <= in_data;
      ch_cur   <= in_ch;
      coef_act <= coef;
    end
  end

  // History advances only when the result is handed off (post-saturation y).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else if (idle && hist_clr) begin
      for (int i = 0; i < NCH; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else if (out_valid && out_ready) begin
      x2[ch_cur] <= x1[ch_cur];
      x1[ch_cur] <= x_cur;
      y2[ch_cur] <= y1[ch_cur];
      y1[ch_cur] <= y_out;
    end
  end

  iir_mac #(
    .AW    (MW),
    .BW    (CW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (mac_en),
    .clr  (mac_clr),
    .sub  (mac_sub),
    .coef (mac_coef),
    .opnd (mac_opnd),
    .acc  (acc)
  );

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Bench for iir_biquad_tdm. Two instances share clk/rst:
//   dut 0: NCH=2, SAT=1 (clamp)   dut 1: NCH=1, SAT=0 (wrap)
module tb_iir_biquad_tdm;

  localparam int NOHARD = 99999;

  typedef struct { int y; int ch; int t; } exp_t;
  typedef struct { int d; int ch; int x; int yh; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               in_valid   [2];
  logic               in_ready   [2];
  logic signed [7:0]  in_data    [2];
  logic [0:0]         in_ch      [2];
  logic               out_valid  [2];
  logic               out_ready  [2];
  logic signed [8:0]  out_data   [2];
  logic [0:0]         out_ch     [2];
  logic               coef_we    [2];
  logic [2:0]         coef_sel   [2];
  logic signed [13:0] coef_wdata [2];
  logic               hist_clr   [2];
  logic [1:0]         err        [2];

  iir_biquad_tdm #(.NCH(2), .SAT(1), .ROUND(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ch(in_ch[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ch(out_ch[0]),
    .coef_we(coef_we[0]), .coef_sel(coef_sel[0]), .coef_wdata(coef_wdata[0]),
    .hist_clr(hist_clr[0]), .err(err[0])
  );

  iir_biquad_tdm #(.NCH(1), .SAT(0), .ROUND(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ch(in_ch[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ch(out_ch[1]),
    .coef_we(coef_we[1]), .coef_sel(coef_sel[1]), .coef_wdata(coef_wdata[1]),
    .hist_clr(hist_clr[1]), .err(err[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state: [dut][...]
  longint mc  [2][5];
  longint mx1 [2][2];
  longint mx2 [2][2];
  longint my1 [2][2];
  longint my2 [2][2];
  int     nch_of [2];

  vec_t tv [22];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clr(input int d);
    for (int c = 0; c < 2; c++) begin
      mx1[d][c] = 0; mx2[d][c] = 0; my1[d][c] = 0; my2[d][c] = 0;
    end
  endfunction

  function automatic void model_reset(input int d);
    mc[d][0] = 2048; mc[d][1] = 988; mc[d][2] = 2048; mc[d][3] = -1099; mc[d][4] = 699;
    model_clr(d);
  endfunction

  function automatic longint model_step(input int d, input int ch, input longint x);
    longint acc, y;
    acc = mc[d][0] * x + mc[d][1] * mx1[d][ch] + mc[d][2] * mx2[d][ch]
        - mc[d][3] * my1[d][ch] - mc[d][4] * my2[d][ch];
    y = acc >>> 11;
    if (d == 0) begin
      if (y > 255) y = 255;
      if (y < -256) y = -256;
    end else begin
      y = y & 511;
      if (y >= 256) y = y - 512;
    end
    mx2[d][ch] = mx1[d][ch]; mx1[d][ch] = x;
    my2[d][ch] = my1[d][ch]; my1[d][ch] = y;
    return y;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; drives one sample (optionally with a coefficient write).
  task automatic send(input int d, input int ch, input int x, input int yh,
                      input bit we, input int sel, input int wd);
    int n;
    exp_t e;
    longint ym;
    n = 0;
    while (!in_ready[d] && n < 60) begin
      tick();
      n++;
    end
    chk($sformatf("d%0d in_ready_wait", d), longint'(in_ready[d]), 1);
    in_valid[d]   = 1'b1;
    in_ch[d]      = 1'(ch);
    in_data[d]    = 8'(x);
    coef_we[d]    = we;
    coef_sel[d]   = 3'(sel);
    coef_wdata[d] = 14'(wd);
    if (ch < nch_of[d]) begin
      ym   = model_step(d, ch, longint'(x));
      e.y  = (yh == NOHARD) ? int'(ym) : yh;
      e.ch = ch;
      e.t  = cyc;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (we && sel < 5) mc[d][sel] = longint'(wd);
    tick();
    in_valid[d] = 1'b0;
    coef_we[d]  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_pending", longint'(q0.size() + q1.size()), 0);
    tick();
  endtask

  task automatic clear_hist(input int d);
    hist_clr[d] = 1'b1;
    tick();
    hist_clr[d] = 1'b0;
    model_clr(d);
  endtask

  task automatic apply_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++)
      send(tv[i].d, tv[i].ch, tv[i].x, tv[i].yh, 1'b0, 0, 0);
  endtask

  // Scoreboard: latency on the rising edge of out_valid, data/ch at the handshake.
  task automatic monitor();
    bit   prev [2];
    exp_t e;
    prev[0] = 1'b0;
    prev[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (out_valid[d]) begin
          if (!prev[d] && qsize(d) != 0) begin
            e = (d == 0) ? q0[0] : q1[0];
            chk($sformatf("d%0d latency", d), longint'(cyc - e.t), 6);
          end
          if (out_ready[d]) begin
            if (qsize(d) == 0) begin
              chk($sformatf("d%0d unexpected_out", d), longint'(out_valid[d]), 0);
            end else begin
              if (d == 0) e = q0.pop_front();
              else        e = q1.pop_front();
              chk($sformatf("d%0d out_data", d), longint'(out_data[d]), longint'(e.y));
              chk($sformatf("d%0d out_ch", d), longint'(out_ch[d]), longint'(e.ch));
            end
          end
        end
        prev[d] = out_valid[d];
      end
    end
  endtask

  initial begin
    logic signed [8:0] hold_d;
    logic [0:0]        hold_c;
    bit                seen;
    int                n;

    nch_of[0] = 2;
    nch_of[1] = 1;
    model_reset(0);
    model_reset(1);

    // Interleaved impulse on dut0: ch0 impulse, ch1 silence
    tv[0]  = '{0, 0, 1, 1};
    tv[1]  = '{0, 1, 0, 0};
    tv[2]  = '{0, 0, 0, 1};
    tv[3]  = '{0, 1, 0, 0};
    tv[4]  = '{0, 0, 0, NOHARD};
    tv[5]  = '{0, 1, 0, 0};
    tv[6]  = '{0, 0, 0, NOHARD};
    tv[7]  = '{0, 1, 0, 0};
    tv[8]  = '{0, 0, 0, NOHARD};
    tv[9]  = '{0, 1, 0, 0};
    // DC step on dut1 (wrap): 127, then 256 wraps to -256
    tv[10] = '{1, 0, 127, 127};
    tv[11] = '{1, 0, 127, -256};
    tv[12] = '{1, 0, 127, NOHARD};
    tv[13] = '{1, 0, 127, NOHARD};
    tv[14] = '{1, 0, 127, NOHARD};
    tv[15] = '{1, 0, 127, NOHARD};
    // DC step on dut0 ch0 (clamp) after a history clear
    tv[16] = '{0, 0, 127, 127};
    tv[17] = '{0, 0, 127, 255};
    tv[18] = '{0, 0, 127, 255};
    tv[19] = '{0, 0, 127, 255};
    tv[20] = '{0, 0, 127, 255};
    tv[21] = '{0, 0, 127, 255};

    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_ch[d] = '0; out_ready[d] = 1'b1;
      coef_we[d] = 1'b0; coef_sel[d] = '0; coef_wdata[d] = '0; hist_clr[d] = 1'b0;
    end

    repeat (3) tick();
    rst = 1'b0;
    tick();
    fork
      monitor();
    join_none

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst_in_ready", d), longint'(in_ready[d]), 1);
      chk($sformatf("d%0d rst_out_valid", d), longint'(out_valid[d]), 0);
      chk($sformatf("d%0d rst_out_data", d), longint'(out_data[d]), 0);
      chk($sformatf("d%0d rst_out_ch", d), longint'(out_ch[d]), 0);
      chk($sformatf("d%0d rst_err", d), longint'(err[d]), 0);
    end

    apply_table(0, 16);
    drain();
    clear_hist(0);
    apply_table(16, 22);
    drain();

    // Backpressure on dut0 ch1 (ch1 history is still zero)
    out_ready[0] = 1'b0;
    send(0, 1, 5, 5, 1'b0, 0, 0);
    n = 0;
    while (!out_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp out_valid_wait", longint'(out_valid[0]), 1);
    hold_d = out_data[0];
    hold_c = out_ch[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp out_valid_held", longint'(out_valid[0]), 1);
      chk("bp out_data_stable", longint'(out_data[0]), longint'(hold_d));
      chk("bp out_ch_stable", longint'(out_ch[0]), longint'(hold_c));
      chk("bp in_ready_low", longint'(in_ready[0]), 0);
    end
    tick();
    out_ready[0] = 1'b1;
    tick();
    chk("bp in_ready_after", longint'(in_ready[0]), 1);
    // acc = 988*5 + 1099*5 = 10435 -> 5 ; proves the committed history
    send(0, 1, 0, 5, 1'b0, 0, 0);
    drain();

    // Coefficient writes on dut0
    clear_hist(0);
    coef_we[0] = 1'b1; coef_sel[0] = 3'd0; coef_wdata[0] = 14'sd1024;
    tick();
    coef_we[0] = 1'b0;
    mc[0][0] = 1024;
    chk("wr_idle err", longint'(err[0]), 0);
    send(0, 0, 4, 2, 1'b0, 0, 0);
    drain();

    send(0, 0, 0, NOHARD, 1'b0, 0, 0);
    repeat (3) tick();
    coef_we[0] = 1'b1; coef_sel[0] = 3'd0; coef_wdata[0] = 14'sd100;
    tick();
    coef_we[0] = 1'b0;
    chk("wr_busy err", longint'(err[0]), 1);
    drain();
    clear_hist(0);
    send(0, 0, 4, 2, 1'b0, 0, 0);
    drain();

    clear_hist(0);
    send(0, 0, 4, 2, 1'b1, 0, 512);
    drain();
    clear_hist(0);
    send(0, 0, 4, 1, 1'b0, 0, 0);
    drain();

    coef_we[0] = 1'b1; coef_sel[0] = 3'd6; coef_wdata[0] = 14'sd0;
    tick();
    coef_we[0] = 1'b0;
    chk("wr_sel6 err", longint'(err[0]), 1);
    tick();
    chk("err_one_cycle", longint'(err[0]), 0);
    clear_hist(0);
    send(0, 0, 4, 1, 1'b0, 0, 0);
    drain();

    // Bad channel on dut1 (NCH=1, in_ch=1)
    send(1, 1, 7, NOHARD, 1'b0, 0, 0);
    chk("badch err", longint'(err[1]), 2);
    chk("badch in_ready", longint'(in_ready[1]), 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid[1]) seen = 1'b1;
    end
    chk("badch no_output", longint'(seen), 0);
    tick();
    send(1, 0, 3, NOHARD, 1'b0, 0, 0);
    drain();

    // Reset while dut0 is in MAC2
    send(0, 0, 9, NOHARD, 1'b0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    model_reset(0);
    model_reset(1);
    chk("rstmid out_valid", longint'(out_valid[0]), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid in_ready", longint'(in_ready[0]), 1);
    chk("rstmid err", longint'(err[0]), 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    chk("rstmid no_output", longint'(seen), 0);
    tick();
    send(0, 0, 1, 1, 1'b0, 0, 0);
    send(0, 0, 0, 1, 1'b0, 0, 0);
    send(0, 0, 0, NOHARD, 1'b0, 0, 0);
    send(0, 0, 0, NOHARD, 1'b0, 0, 0);
    send(0, 0, 0, NOHARD, 1'b0, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
